// File: rtl/icache_data_ram_pkg.sv
// -----------------------------------------------------------------------------
// icache_data_ram_pkg
// Shared I-cache geometry constants and the data-array word/address types.
// The RAM word address is {line index, word offset}, so RAM_ADDR_W is derived
// from the geometry rather than stated on its own.
// -----------------------------------------------------------------------------
package icache_data_ram_pkg;

   localparam int LINE_COUNT     = 64;
   localparam int WORDS_PER_LINE = 16;
   localparam int INDEX_W        = 6;
   localparam int OFFSET_W       = 4;
   localparam int RAM_ADDR_W     = INDEX_W + OFFSET_W;
   localparam int DATABUS_W      = 32;

   typedef logic [INDEX_W-1:0]    line_index_t;
   typedef logic [OFFSET_W-1:0]   word_offset_t;
   typedef logic [RAM_ADDR_W-1:0] ram_addr_t;
   typedef logic [DATABUS_W-1:0]  data_word_t;

   // Builds the RAM word address from a line index and a word offset.
   function automatic ram_addr_t ram_addr(input line_index_t index,
                                          input word_offset_t offset);
      return {index, offset};
   endfunction

endpackage : icache_data_ram_pkg

// File: rtl/icache_data_ram.sv
// -----------------------------------------------------------------------------
// icache_data_ram
// Instruction-cache data array: simple dual-port RAM, one write port and one
// synchronous read port with 1-cycle, read-first latency.
//
// Ports:
//   aclk     - clock, all state updates on the rising edge
//   aresetn  - asynchronous active-low reset; clears dout only
//   wen      - write enable (one word per cycle, no byte enables)
//   adw      - write word address
//   adr      - read word address (sampled every cycle, no read enable)
//   din      - write data
//   dout     - read data, valid one cycle after adr is sampled
// -----------------------------------------------------------------------------
module icache_data_ram
   import icache_data_ram_pkg::*;
#(
   parameter int ADDR_W = RAM_ADDR_W,
   parameter int DATA_W = DATABUS_W
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              wen,
   input  logic [ADDR_W-1:0] adw,
   input  logic [ADDR_W-1:0] adr,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

   localparam int DEPTH = 2 ** ADDR_W;

   // The array and its read register carry no reset so the pair maps onto a
   // block RAM with its internal registered read. The reset behaviour of dout
   // comes from a separate one-bit flag that masks the read register.
   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [DATA_W-1:0] rd_data_r;
   logic              out_valid_r;
   logic              wr_en_s;

   // A write coinciding with an asserted reset is discarded.
   always_comb begin
      wr_en_s = wen & aresetn;
   end

   // Write port: one full word per enabled cycle.
   always_ff @(posedge aclk) begin
      if (wr_en_s) begin
         mem_r[adw] <= din;
      end
   end

   // Read port: samples every cycle; non-blocking update gives read-first
   // behaviour when adr equals adw on a write edge.
   always_ff @(posedge aclk) begin
      rd_data_r <= mem_r[adr];
   end

   // Output qualifier: drops at once on reset, rises on the first edge after
   // release, which is the same edge that loads a fresh read into rd_data_r.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= 1'b1;
      end
   end

   // Output stage: both operands are registers, so dout only moves at a clock
   // edge or on reset assertion.
   always_comb begin
      dout = {DATA_W{1'b0}};
      if (out_valid_r) begin
         dout = rd_data_r;
      end else begin
         dout = {DATA_W{1'b0}};
      end
   end

endmodule : icache_data_ram

// File: tb/tb_icache_data_ram.sv
// -----------------------------------------------------------------------------
// tb_icache_data_ram
// Directed self-checking bench for icache_data_ram. Inputs change and outputs
// are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_icache_data_ram;
   import icache_data_ram_pkg::*;

   localparam int AW = RAM_ADDR_W;
   localparam int DW = DATABUS_W;

   logic          aclk;
   logic          aresetn;
   logic          wen;
   logic [AW-1:0] adw;
   logic [AW-1:0] adr;
   logic [DW-1:0] din;
   logic [DW-1:0] dout;

   int errors;
   int checks;

   icache_data_ram #(
      .ADDR_W (AW),
      .DATA_W (DW)
   ) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .wen     (wen),
      .adw     (adw),
      .adr     (adr),
      .din     (din),
      .dout    (dout)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [DW-1:0] obs,
                        input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wen = 1'b1;
      adw = a;
      din = d;
      step();
      wen = 1'b0;
   endtask

   initial begin
      errors  = 0;
      checks  = 0;
      aresetn = 1'b0;
      wen     = 1'b0;
      adw     = 10'h000;
      adr     = 10'h000;
      din     = 32'h0000_0000;

      // Reset held with the clock running.
      #2;
      check("reset_async", dout, 32'h0000_0000);
      for (int i = 0; i < 3; i++) begin
         step();
         check("reset_hold", dout, 32'h0000_0000);
      end
      aresetn = 1'b1;
      step();   // reads never-written address 0x000: value undefined, masked

      // Line fill of the last line, one word per cycle.
      for (int i = 0; i < 16; i++) begin
         wen = 1'b1;
         adw = ram_addr(6'h3F, 4'(i));
         din = 32'hA000_0000 + 32'(i);
         step();
      end
      wen = 1'b0;

      // Read the line back, 1-cycle latency per address.
      for (int i = 0; i < 16; i++) begin
         adr = 10'h3F0 + 10'(i);
         step();
         check($sformatf("fill_rd_%0d", i), dout, 32'hA000_0000 + 32'(i));
      end

      // Latency: dout follows adr only at the edge.
      write_word(10'h005, 32'h1234_5678);
      adr = 10'h3F0;
      step();
      check("lat_pre", dout, 32'hA000_0000);
      adr = 10'h005;
      #2;
      check("lat_midcycle", dout, 32'hA000_0000);
      adr = 10'h3F5;
      #1;
      check("lat_adr_change", dout, 32'hA000_0000);
      adr = 10'h005;
      step();
      check("lat_post", dout, 32'h1234_5678);

      // Read-during-write on the same address is read-first.
      write_word(10'h010, 32'h1111_1111);
      wen = 1'b1;
      adw = 10'h010;
      adr = 10'h010;
      din = 32'h2222_2222;
      step();
      wen = 1'b0;
      check("rdw_old", dout, 32'h1111_1111);
      step();
      check("rdw_new", dout, 32'h2222_2222);

      // Independent ports.
      write_word(10'h021, 32'h0BAD_F00D);
      wen = 1'b1;
      adw = 10'h020;
      adr = 10'h021;
      din = 32'hDEAD_BEEF;
      step();
      wen = 1'b0;
      check("indep_rd", dout, 32'h0BAD_F00D);
      adr = 10'h020;
      step();
      check("indep_wr", dout, 32'hDEAD_BEEF);

      // Async reset in the middle of a fill.
      wen = 1'b1;
      adw = 10'h000;
      din = 32'hB000_0000;
      adr = 10'h3F0;
      step();
      check("rst_mid_pre", dout, 32'hA000_0000);
      adw = 10'h3F1;
      din = 32'hFFFF_FFFF;
      #2;
      aresetn = 1'b0;
      #1;
      check("rst_mid_drop", dout, 32'h0000_0000);
      step();   // write to 0x3F1 on this edge must be discarded
      check("rst_mid_hold", dout, 32'h0000_0000);
      wen     = 1'b0;
      aresetn = 1'b1;
      adr     = 10'h3F0;
      step();
      check("rst_after_3f0", dout, 32'hA000_0000);
      adr = 10'h3F1;
      step();
      check("rst_discard_3f1", dout, 32'hA000_0001);
      adr = 10'h000;
      step();
      check("rst_pre_wr_000", dout, 32'hB000_0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_icache_data_ram
